muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit that sits beside the ALU in the EX stage of the pipelined core.
- Accepts one operation at a time, encoded by funct3, and runs it for a fixed number of cycles.
- Holds busy so the hazard logic can stall IF/ID/EX, then pulses done with the result and the destination register tag for the EX/MEM register.
- Operand width is parameterised.

---
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, with sign correction and RISC-V special cases applied in FIX.
module muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [TAGW-1:0] rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] rd_out
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [TAGW-1:0]   rd_q, rdo_q;
  logic [XLEN-1:0]   a_q, divisor_q, res_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, divz_q, ovf_q;
  logic [CW-1:0]     cnt_q;

  logic              accept, last_iter;
  logic              a_sgn, b_sgn, neg_a, neg_b, res_neg, divz, ovf;
  logic [XLEN-1:0]   mag_a, mag_b, addend, quo_s, rem_s, fix_res;
  logic [XLEN:0]     sum, trial;
  logic [2*XLEN-1:0] prod_s;

  assign accept    = (state_q == IDLE || state_q == DONE) && start && !kill;
  assign last_iter = (cnt_q == CW'(XLEN - 1));

  // Operand decode: op[2] selects divide; op[0]=0 marks the signed divides.
  always_comb begin
    a_sgn   = op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    b_sgn   = op[2] ? ~op[0] : (op[1:0] == 2'b01);
    neg_a   = a_sgn & a[XLEN-1];
    neg_b   = b_sgn & b[XLEN-1];
    mag_a   = neg_a ? -a : a;
    mag_b   = neg_b ? -b : b;
    res_neg = (op[2] && op[1]) ? neg_a : (neg_a ^ neg_b);
    divz    = op[2] && (b == '0);
    ovf     = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
  end

  // acc holds {hi, lo}: product accumulator for multiply, {remainder, quotient} for divide.
  always_comb begin
    addend = acc_q[0] ? divisor_q : '0;
    sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
    trial  = acc_q[2*XLEN-1:XLEN-1] - {1'b0, divisor_q};
    if (op_q[2]) begin
      if (trial[XLEN]) acc_d = {acc_q[2*XLEN-2:0], 1'b0};
      else             acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = {sum, acc_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_s = neg_q ? -acc_q : acc_q;
    quo_s  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      3'b000:                 fix_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = divz_q ? '1 : (ovf_q ? MIN_NEG : quo_s);
      default:                fix_res = divz_q ? a_q : (ovf_q ? '0 : rem_s);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = accept ? CALC : IDLE;
      CALC:       state_d = kill ? IDLE : (last_iter ? FIX : CALC);
      FIX:        state_d = kill ? IDLE : DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC) || (state_q == FIX);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      rd_q      <= '0;
      rdo_q     <= '0;
      a_q       <= '0;
      divisor_q <= '0;
      res_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      divz_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        op_q      <= op;
        rd_q      <= rd_in;
        a_q       <= a;
        divisor_q <= mag_b;
        acc_q     <= {{XLEN{1'b0}}, mag_a};
        neg_q     <= res_neg;
        divz_q    <= divz;
        ovf_q     <= ovf;
        cnt_q     <= '0;
      end else if (state_q == CALC) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == FIX && !kill) begin
        res_q <= fix_res;
        rdo_q <= rd_q;
      end
    end
  end

  assign result = res_q;
  assign rd_out = rdo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, control corner cases
// and random operations compared against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  muldiv_unit #(.XLEN(32), .TAGW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op), .a(a), .b(b),
    .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q;
    longint unsigned ux, uy;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    p = '0;
    q = 0;
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sx / sy; return q[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = ux / uy; return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        q = sx % sy; return q[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  // Drive a request at the falling edge; returns just after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; rd_in = r;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic bad);
    lat = 0;
    bad = !busy;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 lat++;
      if (done) break;
      if (!busy) bad = 1'b1;
    end
  endtask

  task automatic finish_op(input string tag, input logic [31:0] exp, input logic [4:0] r, input int exp_lat,
                           input int lat, input logic bad);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, {31'b0, bad}, 32'd0);
    check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    check({tag, "_res"}, result, exp);
    check({tag, "_rd"}, {27'b0, rd_out}, {27'b0, r});
    last_res = exp;
    last_rd  = r;
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r);
    int   lat;
    logic bad;
    issue(o, x, y, r);
    wait_done(lat, bad);
    finish_op(tag, model(o, x, y), r, 33, lat, bad);
    @(posedge clk);
    #1 check({tag, "_done_fall"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic bad;
    logic seen;
    logic [2:0]  ro;
    logic [31:0] rx, ry;

    #12 check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_res", result, 32'd0);
    check("reset_rd", {27'b0, rd_out}, 32'd0);
    @(negedge clk) rst = 1'b0;

    do_op("mul_neg",  3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    check("mul_neg_const", result, 32'hFFFF_FFEB);
    do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    check("mulh_min_const", result, 32'h4000_0000);
    do_op("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    check("mulhu_const", result, 32'hFFFF_FFFE);
    do_op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    check("mulhsu_const", result, 32'hFFFF_FFFF);
    do_op("mul_wrap", 3'd0, 32'h0001_0000, 32'h0001_0000, 5'd4);
    do_op("div_neg",  3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6);
    check("div_neg_const", result, 32'hFFFF_FFFD);
    do_op("rem_neg",  3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7);
    check("rem_neg_const", result, 32'hFFFF_FFFF);
    do_op("divu",     3'd5, 32'd7, 32'd2, 5'd8);
    do_op("remu",     3'd7, 32'hFFFF_FFFF, 32'd16, 5'd9);
    do_op("div_z",    3'd4, 32'd5, 32'd0, 5'd10);
    do_op("remu_z",   3'd7, 32'd5, 32'd0, 5'd11);
    do_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    do_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    do_op("rem_z_neg", 3'd6, 32'hFFFF_FF00, 32'd0, 5'd14);

    // Kill ten edges after acceptance.
    issue(3'd0, 32'd3, 32'd4, 5'd20);
    repeat (9) @(posedge clk);
    @(negedge clk) kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) seen = 1'b1;
    end
    check("kill_no_done", {31'b0, seen}, 32'd0);
    check("kill_res", result, last_res);
    check("kill_rd", {27'b0, rd_out}, {27'b0, last_rd});

    // start together with kill is dropped.
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7; rd_in = 5'd21;
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    check("startkill_busy", {31'b0, busy}, 32'd0);
    do_op("after_startkill", 3'd5, 32'd100, 32'd7, 5'd22);

    // A second start while busy must not disturb the in-flight op.
    issue(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd23);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9; rd_in = 5'd24;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bad);
    finish_op("start_busy", model(3'd4, 32'hFFFF_FF9C, 32'd7), 5'd23, 27, lat, bad);
    @(posedge clk);
    #1 check("start_busy_idle", {31'b0, busy}, 32'd0);

    // Asynchronous reset between edges, mid-CALC.
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd25);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_res", result, 32'd0);
    check("arst_rd", {27'b0, rd_out}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Back-to-back: second start issued in the DONE cycle.
    issue(3'd3, 32'hDEAD_BEEF, 32'h0000_1234, 5'd26);
    wait_done(lat, bad);
    finish_op("b2b_first", model(3'd3, 32'hDEAD_BEEF, 32'h0000_1234), 5'd26, 33, lat, bad);
    issue(3'd6, 32'hDEAD_BEEF, 32'h0000_1234, 5'd27);
    wait_done(lat, bad);
    finish_op("b2b_second", model(3'd6, 32'hDEAD_BEEF, 32'h0000_1234), 5'd27, 33, lat, bad);

    for (int i = 0; i < 120; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = '0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: begin rx = 32'($urandom_range(0, 40)) - 32'd20; ry = 32'($urandom_range(0, 10)) - 32'd5; end
        default: ;
      endcase
      do_op("rand", ro, rx, ry, 5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
